conv_img_frame_loader: RTL

Streams an input image in pixel beats, assembles a complete frame in an internal buffer and publishes it as one flattened, registered image word for the fully parallel 2-D convolution stage directly downstream. Frames are double-buffered: assembly of frame N+1 overlaps the hold of published frame N, so the convolution stage sees a new, stable image every `BEATS` accepted beats. An 8-bit opaque tag travels with each frame and is presented alongside it for the downstream opaque pipeline.

---
 rtl/conv_img_frame_loader_pkg.sv | 16 +
 rtl/conv_img_frame_loader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/conv_img_frame_loader_pkg.sv
// rtl/conv_img_frame_loader_pkg.sv - shared types and constants for the convolution frame loader
package conv_loader_pkg;

    localparam int OPAQUE_W = 8;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } loader_state_t;

    // A single-beat frame still needs a one-bit counter.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/conv_img_frame_loader.sv
// rtl/conv_img_frame_loader.sv - double-buffered frame assembler feeding a parallel 2-D convolution stage
module conv_img_frame_loader
    import conv_loader_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMG_W        = 8,
    parameter int IMG_H        = 8,
    parameter int IMG_D        = 2,
    parameter int PIX_PER_BEAT = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [PIX_PER_BEAT*DATA_WIDTH-1:0]        in_data,
    input  logic                                      in_last,
    input  logic [OPAQUE_W-1:0]                       in_tag,
    output logic [IMG_D*IMG_H*IMG_W*DATA_WIDTH-1:0]   img_data_out,
    output logic                                      frame_valid,
    output logic [OPAQUE_W-1:0]                       opaque_out,
    output logic                                      err_short,
    output logic                                      err_long,
    output logic [15:0]                               frame_cnt
);

    localparam int NUM_PIX  = IMG_D * IMG_H * IMG_W;
    localparam int BEATS    = NUM_PIX / PIX_PER_BEAT;
    localparam int CNT_W    = beat_cnt_width(BEATS);
    localparam int BEAT_W   = PIX_PER_BEAT * DATA_WIDTH;
    localparam int IMG_BITS = NUM_PIX * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    generate
        if (NUM_PIX % PIX_PER_BEAT != 0) begin : g_bad_pix_per_beat
            $error("conv_img_frame_loader: IMG_D*IMG_H*IMG_W must be divisible by PIX_PER_BEAT");
        end
    endgenerate

    loader_state_t          r_state;
    loader_state_t          w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [OPAQUE_W-1:0]    r_tag;
    logic [IMG_BITS-1:0]    r_asm;
    logic [IMG_BITS-1:0]    w_asm_merged;
    logic [IMG_BITS-1:0]    r_img;
    logic                   r_ready;
    logic                   r_frame_valid;
    logic [OPAQUE_W-1:0]    r_opaque;
    logic                   r_err_short;
    logic                   r_err_long;
    logic [15:0]            r_frame_cnt;

    logic                   w_accept;
    logic                   w_at_last;
    logic                   w_commit;
    logic                   w_err_short;
    logic                   w_err_long;
    logic                   w_tag_cap;
    logic [OPAQUE_W-1:0]    w_frame_tag;

    assign w_accept  = in_valid & r_ready;
    assign w_at_last = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                FILL:    if (!in_last && w_at_last) w_state_next = DRAIN;
                DRAIN:   if (in_last) w_state_next = FILL;
                default: w_state_next = FILL;
            endcase
        end
    end

    always_comb begin
        w_commit    = 1'b0;
        w_err_short = 1'b0;
        w_err_long  = 1'b0;
        w_tag_cap   = 1'b0;
        w_cnt_next  = r_cnt;
        if (w_accept) begin
            case (r_state)
                FILL: begin
                    w_tag_cap = (r_cnt == '0);
                    if (in_last && w_at_last) begin
                        w_commit = 1'b1;
                    end else if (in_last) begin
                        w_err_short = 1'b1;
                    end else if (w_at_last) begin
                        w_err_long = 1'b1;
                    end
                    w_cnt_next = (in_last || w_at_last) ? '0 : r_cnt + 1'b1;
                end
                DRAIN: begin
                    if (in_last) w_cnt_next = '0;
                end
                default: w_cnt_next = '0;
            endcase
        end
    end

    // The tag of a one-beat frame arrives together with its commit.
    assign w_frame_tag = w_tag_cap ? in_tag : r_tag;

    always_comb begin
        w_asm_merged = r_asm;
        w_asm_merged[int'(r_cnt)*BEAT_W +: BEAT_W] = in_data;
    end

    // Assembly storage needs no reset: every location is rewritten before a commit.
    always_ff @(posedge clk) begin
        if (w_accept && r_state == FILL) begin
            r_asm <= w_asm_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready       <= 1'b0;
            r_cnt         <= '0;
            r_tag         <= '0;
            r_img         <= '0;
            r_frame_valid <= 1'b0;
            r_opaque      <= '0;
            r_err_short   <= 1'b0;
            r_err_long    <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_ready       <= 1'b1;
            r_cnt         <= w_cnt_next;
            r_frame_valid <= w_commit;
            r_opaque      <= w_commit ? w_frame_tag : '0;
            r_err_short   <= w_err_short;
            r_err_long    <= w_err_long;
            if (w_tag_cap) begin
                r_tag <= in_tag;
            end
            if (w_commit) begin
                r_img       <= w_asm_merged;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign in_ready     = r_ready;
    assign img_data_out = r_img;
    assign frame_valid  = r_frame_valid;
    assign opaque_out   = r_opaque;
    assign err_short    = r_err_short;
    assign err_long     = r_err_long;
    assign frame_cnt    = r_frame_cnt;

endmodule
